instr_fetch: RTL

- Instruction-side counterpart to the multicycle control FSM: owns the PC and instruction register (IR) and fetches from instruction memory over a req/ack handshake.
- Presents OPCODE[31:28] and MM[27:24] to the controller.
- Accepts fetch and branch commands from the controller.
- Detects HLT (opcode 15) and freezes further fetching.

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ack handshake,
// applies controller branches and freezes on HLT (opcode 15).
module instr_fetch #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_RESET = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              FETCH_EN,
    input  logic              BR_EN,
    input  logic              BR_REL,
    input  logic [ADDR_W-1:0] BR_VAL,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [DATA_W-1:0] IMEM_RDATA,
    output logic [DATA_W-1:0] IR_OUT,
    output logic [3:0]        OPCODE,
    output logic [3:0]        MM,
    output logic [ADDR_W-1:0] IR_PC,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              IR_VALID,
    output logic              BUSY,
    output logic              FETCH_ERR,
    output logic              HALTED
);

    localparam int unsigned CNT_W = 8;
    localparam logic [3:0]  OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic                fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   br_target;

    // Branch target: absolute value, or IR_PC plus a same-width two's-complement offset
    always_comb begin
        br_target = BR_VAL;
        if (BR_REL) begin
            br_target = ir_pc_q + BR_VAL;
        end
    end

    // State register and fetch datapath
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q     <= S_IDLE;
            pc_q        <= ADDR_W'(PC_RESET);
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: branch/fetch in IDLE, ack/timeout in REQ, HALT is sticky
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = 1'b0;
        fetch_err_d = 1'b0;
        cnt_d       = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (BR_EN) begin
                    pc_d = br_target;
                end
                if (FETCH_EN) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (IMEM_ACK) begin
                    ir_d       = IMEM_RDATA;
                    ir_pc_d    = pc_q;
                    pc_d       = pc_q + ADDR_W'(1);
                    ir_valid_d = 1'b1;
                    state_d    = (IMEM_RDATA[31:28] == OP_HLT) ? S_HALT : S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Timeout fires on the edge closing the TIMEOUT-th REQ cycle
                    fetch_err_d = 1'b1;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        IMEM_REQ  = (state_q == S_REQ);
        BUSY      = (state_q == S_REQ);
        HALTED    = (state_q == S_HALT);
        IMEM_ADDR = pc_q;
        PC_OUT    = pc_q;
        IR_OUT    = ir_q;
        OPCODE    = ir_q[31:28];
        MM        = ir_q[27:24];
        IR_PC     = ir_pc_q;
        IR_VALID  = ir_valid_q;
        FETCH_ERR = fetch_err_q;
    end

endmodule
